// File: rtl/sbox_seq.sv
// Sequencer that splits a 48-bit word into eight 6-bit chunks, feeds them
// one per cycle to a shared S-box unit and gathers the eight 4-bit results.
module sbox_seq #(
  parameter int SBOX_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [47:0] in_data,
  output logic        sbox_en,
  output logic [2:0]  sbox_sel,
  output logic [5:0]  sbox_din,
  input  logic [3:0]  sbox_dout,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic        r_arm;
  logic [47:0] r_word;
  logic [2:0]  r_k;
  logic        r_k_term;
  logic [31:0] r_res;

  logic [SBOX_LAT-1:0] r_dv;
  logic [2:0]          r_di [SBOX_LAT];

  logic       w_acc;
  logic       w_cap;
  logic [2:0] w_cap_idx;
  logic [5:0] w_chunk;

  assign w_acc     = (r_state == S_IDLE) & in_valid & r_arm;
  assign w_cap     = r_dv[SBOX_LAT-1];
  assign w_cap_idx = r_di[SBOX_LAT-1];

  always_comb begin
    w_chunk = 6'd0;
    for (int i = 0; i < 8; i++) begin
      if (r_k == 3'(i)) w_chunk = r_word[47-6*i -: 6];
    end
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    sbox_en   = 1'b0;
    sbox_sel  = 3'd0;
    sbox_din  = 6'd0;
    out_valid = 1'b0;
    out_data  = 32'd0;
    busy      = 1'b1;
    unique case (r_state)
      S_IDLE: begin
        busy     = 1'b0;
        in_ready = r_arm;
        if (w_acc) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        sbox_en  = 1'b1;
        sbox_sel = r_k;
        sbox_din = w_chunk;
        if (r_k == 3'd7) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_cap && w_cap_idx == 3'd7) w_next = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        out_data  = r_res;
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // r_arm keeps in_ready low until the first edge after reset release
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_arm    <= 1'b0;
      r_word   <= 48'd0;
      r_k      <= 3'd0;
      r_k_term <= 1'b0;
    end else begin
      r_state <= w_next;
      r_arm   <= 1'b1;
      if (w_acc) begin
        r_word   <= in_data;
        r_k      <= 3'd0;
        r_k_term <= 1'b0;
      end else if (r_state == S_ISSUE && !r_k_term) begin
        if (r_k == 3'd7) r_k_term <= 1'b1;
        else             r_k      <= r_k + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dv <= '0;
      for (int i = 0; i < SBOX_LAT; i++) r_di[i] <= 3'd0;
    end else begin
      r_dv[0] <= sbox_en;
      r_di[0] <= sbox_sel;
      for (int i = 1; i < SBOX_LAT; i++) begin
        r_dv[i] <= r_dv[i-1];
        r_di[i] <= r_di[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_res <= 32'd0;
    end else if (w_acc) begin
      r_res <= 32'd0;
    end else if (r_state == S_DONE && out_ready) begin
      r_res <= 32'd0;
    end else if (w_cap) begin
      for (int i = 0; i < 8; i++) begin
        if (w_cap_idx == 3'(i)) r_res[31-4*i -: 4] <= sbox_dout;
      end
    end
  end

endmodule

// File: doc/sbox_seq.md
SBOX_SEQ -- requirements
Module: sbox_seq

Interface
REQ-001 SHALL have parameter SBOX_LAT, default 1, meaning cycles from sbox_en to valid sbox_dout of the shared S-box lookup unit (legal 1..4).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  48-bit expanded/keyed word offered.
REQ-005 SHALL have port in_ready  output  1  block accepts a word this cycle.
REQ-006 SHALL have port in_data  input  48  word to substitute; chunk i = in_data[47-6i:42-6i], i=0..7.
REQ-007 SHALL have port sbox_en  output  1  issue strobe to the shared lookup unit.
REQ-008 SHALL have port sbox_sel  output  3  S-box index (0 = S1 ... 7 = S8) for the issued chunk.
REQ-009 SHALL have port sbox_din  output  6  6-bit chunk presented to the lookup unit.
REQ-010 SHALL have port sbox_dout  input  4  lookup result, valid SBOX_LAT cycles after the matching sbox_en.
REQ-011 SHALL have port out_valid  output  1  32-bit substituted result available.
REQ-012 SHALL have port out_ready  input  1  downstream accepts result.
REQ-013 SHALL have port out_data  output  32  result; nibble i at out_data[31-4i:28-4i].
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-015 SHALL implement states IDLE, ISSUE, DRAIN, DONE.
REQ-016 SHALL assert in_ready only in IDLE; accept when in_valid & in_ready, latch in_data, clear result register, go to ISSUE.
REQ-017 In ISSUE, SHALL drive sbox_en=1, sbox_sel=issue count k, sbox_din=chunk k, for k=0..7 on 8 consecutive cycles, then go to DRAIN (skip DRAIN if SBOX_LAT=1 and last capture is complete).
REQ-018 SHALL hold sbox_en=0, sbox_sel=0, sbox_din=0 outside ISSUE.
REQ-019 SHALL track issues with a delay line of depth SBOX_LAT carrying valid and index, and capture sbox_dout into nibble index when the delayed valid is set.
REQ-020 SHALL enter DONE the cycle after the 8th capture and assert out_valid with out_data stable there.
REQ-021 Latency: with accept at cycle T, out_valid SHALL first be high at T+9+SBOX_LAT (T+10 for SBOX_LAT=1).
REQ-022 SHALL hold out_valid and out_data until out_valid & out_ready, then return to IDLE next cycle; in_ready first high the cycle after the handshake (no same-cycle bypass).
REQ-023 SHALL ignore in_valid while busy; in_data changes while busy SHALL NOT affect the result.
REQ-024 SHALL clear out_data to 0 on leaving DONE.
REQ-025 Index counters SHALL be 3 bits plus terminal flag; no wrap past chunk 7 within one word.
REQ-026 out_ready high outside DONE SHALL have no effect.

Reset
REQ-027 On reset assertion, SHALL immediately (asynchronously) enter IDLE and force in_ready=0 while reset high, sbox_en=0, sbox_sel=0, sbox_din=0, out_valid=0, out_data=0, busy=0, delay line cleared.
REQ-028 Reset mid-operation SHALL discard the partial result; late sbox_dout values after deassertion SHALL NOT be captured.
REQ-029 in_ready SHALL rise the first clock edge after reset deassertion.

Verification
REQ-030 SBOX_LAT=1, bench lookup model dout = din[3:0] registered; in_data=48'h0420C41461C8 (chunks 1..8), out_ready=1 -> out_valid at T+10, out_data=32'h12345678, sbox_sel 0..7 on T+1..T+8.
REQ-031 Same stimulus, SBOX_LAT=3 -> out_valid at T+12, out_data=32'h12345678; sbox_en exactly 8 cycles high.
REQ-032 out_ready=0 for 5 cycles after out_valid -> out_valid and out_data=32'h12345678 held; in_valid high throughout not accepted; in_ready high the cycle after handshake.
REQ-033 Reset pulsed at issue k=4 -> all outputs 0 within same cycle; next word 48'h0 yields out_data=32'h0 with no residue from prior word.
REQ-034 Back-to-back: in_valid held high with two words 48'h0420C41461C8 then 48'hFFFFFFFFFFFF -> results 32'h12345678 then 32'hFFFFFFFF, second accept exactly one cycle after first out handshake.
